// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding the UART transmitter with a
// first-word-fall-through valid/ready source, plus occupancy, full, empty
// and sticky overflow status for the CSR read path.
// Optional build macro UART_TX_FIFO_LOWATER_EN adds a registered low-water
// flag (next count <= thresh_i); without it lowater_o is tied low.
module uart_tx_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [7:0]       push_data_i,
  input  logic             clear_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o,
  input  logic [CNT_W-1:0] thresh_i,
  output logic             lowater_o
);

  logic [7:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, cnt_nxt;
  logic              overflow;
  logic              push_ok, pop;

  // status is derived from the registered count only
  assign full_o     = (count == CNT_W'(DEPTH));
  assign empty_o    = (count == '0);
  assign count_o    = count;
  assign overflow_o = overflow;
  assign tx_valid_o = !empty_o;
  assign tx_data_o  = mem[rd_ptr];

  // full is judged before any same-cycle pop, so a push into a full FIFO drops
  assign push_ok = push_i && !full_o;
  assign pop     = tx_valid_o && tx_ready_i;

  // next occupancy; clear wins over any coincident push/pop
  always_comb begin
    cnt_nxt = count;
    if (clear_i)
      cnt_nxt = '0;
    else if (push_ok && !pop)
      cnt_nxt = count + CNT_W'(1);
    else if (pop && !push_ok)
      cnt_nxt = count - CNT_W'(1);
  end

  // pointer, count and sticky overflow state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)           wr_ptr   <= wr_ptr + ADDR_W'(1);
      if (pop)               rd_ptr   <= rd_ptr + ADDR_W'(1);
      if (push_i && full_o)  overflow <= 1'b1;
      count <= cnt_nxt;
    end
  end

  // storage write; contents are never reset
  always_ff @(posedge clk_i) begin
    if (rst_ni && !clear_i && push_ok)
      mem[wr_ptr] <= push_data_i;
  end

`ifdef UART_TX_FIFO_LOWATER_EN
  // low-water flag tracks the next count so it lines up with count_o
  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      lowater_o <= 1'b0;
    else
      lowater_o <= (cnt_nxt <= thresh_i);
  end
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh_i;
  assign lowater_o     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo (DEPTH=4): queue-based reference
// model checked every cycle, directed scenarios with literal expectations,
// then a randomized phase.
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_ni, push_i, clear_i, tx_ready_i;
  logic [7:0]       push_data_i;
  logic [CNT_W-1:0] thresh_i;
  logic [7:0]       tx_data_o;
  logic             tx_valid_o, full_o, empty_o, overflow_o, lowater_o;
  logic [CNT_W-1:0] count_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

`ifdef UART_TX_FIFO_LOWATER_EN
  localparam bit LOW_EN = 1'b1;
`else
  localparam bit LOW_EN = 1'b0;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .push_i(push_i), .push_data_i(push_data_i),
    .clear_i(clear_i), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i), .count_o(count_o), .full_o(full_o),
    .empty_o(empty_o), .overflow_o(overflow_o), .thresh_i(thresh_i),
    .lowater_o(lowater_o)
  );

  always #5 clk = ~clk;

  // reference model: contents as a queue, sticky overflow, low-water flag
  logic [7:0] q[$];
  bit         m_ovf = 1'b0;
  bit         m_low = 1'b0;

  always @(posedge clk) begin
    if (!rst_ni) begin
      q.delete(); m_ovf = 1'b0; m_low = 1'b0;
    end else if (clear_i) begin
      q.delete(); m_ovf = 1'b0; m_low = LOW_EN;
    end else begin
      bit was_full, do_pop;
      was_full = (q.size() == DEPTH);
      do_pop   = (q.size() != 0) && tx_ready_i;
      if (push_i && was_full) m_ovf = 1'b1;
      if (do_pop) void'(q.pop_front());
      if (push_i && !was_full) q.push_back(push_data_i);
      m_low = LOW_EN && (q.size() <= int'(thresh_i));
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", tx_valid_o, q.size() != 0);
      if (q.size() != 0) chk("m_data", tx_data_o, q[0]);
      chk("m_count", count_o, q.size());
      chk("m_full",  full_o,  q.size() == DEPTH);
      chk("m_empty", empty_o, q.size() == 0);
      chk("m_ovf",   overflow_o, m_ovf);
      chk("m_low",   lowater_o,  m_low);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(logic [7:0] d);
    push_i = 1'b1; push_data_i = d; tick(); push_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1; tick(); clear_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; push_i = 1'b0; clear_i = 1'b0; tx_ready_i = 1'b0;
    push_data_i = '0; thresh_i = '0;
    tick(); chk_en = 1'b1; tick();
    rst_ni = 1'b1;
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_valid", tx_valid_o, 0);
    chk("rst_low",   lowater_o, 0);

    // single byte, held with ready low
    push(8'h41);
    chk("t1_valid", tx_valid_o, 1);
    chk("t1_data",  tx_data_o, 8'h41);
    chk("t1_count", count_o, 1);
    repeat (5) tick();
    chk("t1_hold_data",  tx_data_o, 8'h41);
    chk("t1_hold_count", count_o, 1);
    do_clear();

    // fill, overflow, drain in order
    for (int i = 1; i <= 4; i++) push(8'(i));
    chk("t2_full",  full_o, 1);
    chk("t2_count", count_o, 4);
    push(8'h05);
    chk("t2_ovf",   overflow_o, 1);
    chk("t2_count4", count_o, 4);
    tx_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t2_drain", tx_data_o, i);
      tick();
    end
    tx_ready_i = 1'b0;
    chk("t2_empty", empty_o, 1);
    do_clear();

    // full with simultaneous push and pop: push dropped, pop proceeds
    for (int i = 1; i <= 4; i++) push(8'(i));
    tx_ready_i = 1'b1; push(8'hAA); tx_ready_i = 1'b0;
    chk("t3_count", count_o, 3);
    chk("t3_ovf",   overflow_o, 1);
    chk("t3_head",  tx_data_o, 8'h02);
    do_clear();

    // steady push+pop at count 2 wraps pointers without changing count
    push(8'h21); push(8'h22);
    begin
      logic [7:0] heads [8];
      heads = '{8'h21, 8'h22, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
      tx_ready_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
        chk("t4_order", tx_data_o, heads[i]);
        push_i = 1'b1; push_data_i = 8'(8'h10 + i); tick();
        chk("t4_count", count_o, 2);
      end
      push_i = 1'b0;
      for (int i = 6; i < 8; i++) begin
        chk("t4_tail", tx_data_o, heads[i]);
        tick();
      end
      tx_ready_i = 1'b0;
      chk("t4_empty", empty_o, 1);
    end

    // clear and reset with a coincident push
    for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
    tx_ready_i = 1'b1; tick(); tx_ready_i = 1'b0;
    chk("t5_pre_count", count_o, 3);
    chk("t5_pre_ovf",   overflow_o, 1);
    clear_i = 1'b1; push(8'h77); clear_i = 1'b0;
    chk("t5_clr_count", count_o, 0);
    chk("t5_clr_ovf",   overflow_o, 0);
    chk("t5_clr_valid", tx_valid_o, 0);
    for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
    tx_ready_i = 1'b1; tick(); tx_ready_i = 1'b0;
    rst_ni = 1'b0; push(8'h78); rst_ni = 1'b1;
    chk("t5_rst_count", count_o, 0);
    chk("t5_rst_ovf",   overflow_o, 0);
    chk("t5_rst_valid", tx_valid_o, 0);

    // low-water threshold
    thresh_i = 3'd1;
    for (int i = 0; i < 3; i++) push(8'(8'h50 + i));
    chk("t6_low_hi", lowater_o, 0);
    tx_ready_i = 1'b1; tick();
    chk("t6_low_c2", lowater_o, 0);
    tick(); tx_ready_i = 1'b0;
    chk("t6_count1", count_o, 1);
    chk("t6_low_c1", lowater_o, LOW_EN);
    do_clear();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      push_i      = ($urandom_range(0, 1) == 1);
      push_data_i = 8'($urandom);
      tx_ready_i  = ($urandom_range(0, 2) != 0);
      clear_i     = ($urandom_range(0, 63) == 0);
      rst_ni      = ($urandom_range(0, 127) != 0);
      thresh_i    = 3'($urandom_range(0, 4));
      tick();
    end
    rst_ni = 1'b1; push_i = 1'b0; clear_i = 1'b0; tx_ready_i = 1'b0;
    tick();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
